// File: rtl/hash_chk_pkg.sv
// Shared types and defaults for the weight-stream hash checker.
package hash_chk_pkg;

    localparam int HASH_W_DEF     = 256;
    localparam int REF_W_DEF      = 64;
    localparam int N_HASH_DEF     = 10;
    localparam int CNT_W_DEF      = 16;
    localparam int WORDS_PER_HASH = HASH_W_DEF / REF_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_POP,
        S_READ,
        S_DRAIN,
        S_RESULT,
        S_DONE,
        S_HALT
    } hash_chk_state_e;

endpackage

// File: rtl/hash_check_ctrl_if.sv
// Hasher pop handshake and reference-RAM read port seen by the checker.
interface hash_check_ctrl_if #(
    parameter int HASH_W = 256,
    parameter int REF_W  = 64,
    parameter int ADDR_W = 6
);
    logic              hash_valid;
    logic [HASH_W-1:0] hash_in;
    logic              hash_pop;
    logic              ref_rd;
    logic [ADDR_W-1:0] ref_addr;
    logic [REF_W-1:0]  ref_rdata;

    // checker side
    modport master (
        input  hash_valid, hash_in, ref_rdata,
        output hash_pop, ref_rd, ref_addr
    );

    // hasher / RAM side
    modport slave (
        output hash_valid, hash_in, ref_rdata,
        input  hash_pop, ref_rd, ref_addr
    );
endinterface

// File: rtl/hash_word_cmp.sv
// Holds the popped hash and folds the per-word compare into one ok flag.
// RAM data arrives one cycle after the read, so the word select is delayed
// to line up with ref_rdata.
module hash_word_cmp #(
    parameter int HASH_W = 256,
    parameter int REF_W  = 64,
    parameter int WI_W   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [HASH_W-1:0] hash_in,
    input  logic              rd,
    input  logic [WI_W-1:0]   word_sel,
    input  logic [REF_W-1:0]  rdata,
    output logic              ok
);
    logic [HASH_W-1:0] hash_q;
    logic              rd_d;
    logic [WI_W-1:0]   sel_d;
    logic [REF_W-1:0]  ref_word;

    assign ref_word = hash_q[sel_d*REF_W +: REF_W];

    // latch on pop, then clear ok on any differing word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hash_q <= '0;
            rd_d   <= 1'b0;
            sel_d  <= '0;
            ok     <= 1'b0;
        end else begin
            rd_d  <= rd;
            sel_d <= word_sel;
            if (load) begin
                hash_q <= hash_in;
                ok     <= 1'b1;
            end else if (rd_d && (rdata != ref_word)) begin
                ok <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/hash_check_ctrl.sv
// Sequences bundle hash checks: pop hash, read 4 reference words, report.
module hash_check_ctrl
    import hash_chk_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF,
    parameter int REF_W  = REF_W_DEF,
    parameter int N_HASH = N_HASH_DEF,
    parameter int ADDR_W = $clog2(N_HASH * HASH_W / REF_W),
    parameter int CNT_W  = CNT_W_DEF,
    localparam int IDX_W = $clog2(N_HASH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               halt_on_err,
    input  logic               bundle_done,
    hash_check_ctrl_if.master  bus,
    output logic               chk_valid,
    output logic               chk_ok,
    output logic [IDX_W-1:0]   chk_idx,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic               err_proto,
    output logic               err_ovf,
    output logic               halted,
    output logic               busy,
    output logic               done
);
    localparam int WI_W  = $clog2(WORDS_PER_HASH);
    localparam int ISS_W = $clog2(N_HASH + 1);

    hash_chk_state_e  state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WI_W-1:0]  w;
    logic [2:0]       pending;
    logic [ISS_W-1:0] issued;
    logic             ok;
    logic             accept_bd, issued_full, can_pop, last_idx, last_word;

    assign busy        = (state == S_WAIT) || (state == S_POP) || (state == S_READ) ||
                         (state == S_DRAIN) || (state == S_RESULT);
    assign accept_bd   = bundle_done && busy && !start;
    assign issued_full = (issued == ISS_W'(N_HASH));
    assign can_pop     = bus.hash_valid && (pending != 3'd0);
    assign last_idx    = (idx == IDX_W'(N_HASH - 1));
    assign last_word   = (w == WI_W'(WORDS_PER_HASH - 1));

    assign bus.hash_pop = (state == S_POP);
    assign bus.ref_rd   = (state == S_READ);
    assign bus.ref_addr = bus.ref_rd ? ADDR_W'(int'(idx) * WORDS_PER_HASH + int'(w)) : '0;
    assign chk_valid    = (state == S_RESULT);
    assign chk_ok       = chk_valid && ok;
    assign chk_idx      = idx;
    assign halted       = (state == S_HALT);
    assign done         = (state == S_DONE);

    hash_word_cmp #(.HASH_W(HASH_W), .REF_W(REF_W), .WI_W(WI_W)) u_cmp (
        .clk      (clk),
        .rstn     (rstn),
        .load     (bus.hash_pop),
        .hash_in  (bus.hash_in),
        .rd       (bus.ref_rd),
        .word_sel (w),
        .rdata    (bus.ref_rdata),
        .ok       (ok)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next state; RESULT may go straight to POP so results can be 7 cycles apart
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_IDLE;
            S_WAIT:   if (can_pop) state_nxt = S_POP;
            S_POP:    state_nxt = S_READ;
            S_READ:   if (last_word) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_RESULT;
            S_RESULT: begin
                if (!ok && halt_on_err) state_nxt = S_HALT;
                else if (last_idx)      state_nxt = S_DONE;
                else if (can_pop)       state_nxt = S_POP;
                else                    state_nxt = S_WAIT;
            end
            S_DONE:   state_nxt = S_DONE;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
        if (start) state_nxt = S_WAIT;
    end

    // index, word counter, pending/issued bookkeeping, counters and sticky errors
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx          <= '0;
            w            <= '0;
            pending      <= 3'd0;
            issued       <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err_proto    <= 1'b0;
            err_ovf      <= 1'b0;
        end else if (start) begin
            idx          <= '0;
            w            <= '0;
            pending      <= 3'd0;
            issued       <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err_proto    <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            if (state == S_POP)       w <= '0;
            else if (state == S_READ) w <= w + 1'b1;

            if (state == S_RESULT && (state_nxt == S_WAIT || state_nxt == S_POP))
                idx <= idx + 1'b1;

            if (state == S_RESULT) begin
                if (ok) begin
                    if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
                end else begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                end
            end

            case ({accept_bd && !issued_full, bus.hash_pop})
                2'b10:   if (pending != 3'd7) pending <= pending + 3'd1;
                2'b01:   pending <= pending - 3'd1;
                default: pending <= pending;
            endcase

            if (accept_bd && !issued_full) issued <= issued + 1'b1;
            if (accept_bd && issued_full)  err_ovf <= 1'b1;
            if (state == S_WAIT && bus.hash_valid && pending == 3'd0) err_proto <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hash_check_ctrl.sv
// Directed bench: hasher queue and reference RAM models around the checker.
module tb_hash_check_ctrl;
    localparam int N_HASH = 3;
    localparam int ADDR_W = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic halt_on_err = 1'b0;
    logic bundle_done = 1'b0;
    logic chk_valid, chk_ok, err_proto, err_ovf, halted, busy, done;
    logic [IDX_W-1:0] chk_idx;
    logic [CNT_W-1:0] match_cnt, mismatch_cnt;

    hash_check_ctrl_if #(.HASH_W(256), .REF_W(64), .ADDR_W(ADDR_W)) bus ();

    hash_check_ctrl #(.N_HASH(N_HASH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .halt_on_err(halt_on_err),
        .bundle_done(bundle_done), .bus(bus), .chk_valid(chk_valid), .chk_ok(chk_ok),
        .chk_idx(chk_idx), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
        .err_proto(err_proto), .err_ovf(err_ovf), .halted(halted), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // hasher model: fifo of finished hashes
    logic [255:0] hq [16];
    int hq_wr = 0;
    int hq_rd = 0;
    assign bus.hash_valid = (hq_wr != hq_rd);
    assign bus.hash_in    = hq[hq_rd % 16];

    // reference RAM model, one-cycle read latency
    logic [63:0] mem [4*N_HASH];
    logic [63:0] rdata_q = '0;
    assign bus.ref_rdata = rdata_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.hash_pop) hq_rd <= hq_rd + 1;
        if (bus.ref_rd) rdata_q <= mem[bus.ref_addr];
    end

    // monitors
    int res_cnt = 0, pop_cnt = 0, addr_cnt = 0;
    int res_cyc [64];
    logic [IDX_W-1:0] res_idx [64];
    logic res_ok [64];
    int pop_cyc [64];
    logic [ADDR_W-1:0] addr_log [64];

    always @(negedge clk) begin
        if (chk_valid) begin
            res_idx[res_cnt % 64] <= chk_idx;
            res_ok[res_cnt % 64]  <= chk_ok;
            res_cyc[res_cnt % 64] <= cyc;
            res_cnt <= res_cnt + 1;
        end
        if (bus.hash_pop) begin
            pop_cyc[pop_cnt % 64] <= cyc;
            pop_cnt <= pop_cnt + 1;
        end
        if (bus.ref_rd) begin
            addr_log[addr_cnt % 64] <= bus.ref_addr;
            addr_cnt <= addr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int i, input int w);
        return 64'hC0DE_5EED_0000_0000 + 64'(i * 256 + w * 17 + 1);
    endfunction

    function automatic logic [255:0] hash_of(input int i);
        logic [255:0] h;
        for (int w = 0; w < 4; w++) h[w*64 +: 64] = word_of(i, w);
        return h;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic load_mem(input bit corrupt);
        for (int i = 0; i < N_HASH; i++)
            for (int w = 0; w < 4; w++) mem[i*4 + w] = word_of(i, w);
        if (corrupt) mem[1*4 + 2] = mem[1*4 + 2] ^ 64'h1;
    endtask

    task automatic do_reset();
        tick(1);
        rstn = 1'b0;
        start = 1'b0;
        bundle_done = 1'b0;
        tick(2);
        hq_wr = hq_rd;
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_hash(input int i);
        hq[hq_wr % 16] = hash_of(i);
        hq_wr++;
    endtask

    task automatic send_bundle(input int i);
        bundle_done = 1'b1;
        tick(1);
        bundle_done = 1'b0;
        push_hash(i);
    endtask

    task automatic wait_res(input int target, input int budget);
        int k = 0;
        while (res_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        check("result_timeout", 64'(res_cnt >= target), 64'd1);
    endtask

    int rb, ab, pb;
    bit popped;

    initial begin
        load_mem(1'b0);
        // reset state
        tick(1);
        check("rst_chk_valid", 64'(chk_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_hash_pop", 64'(bus.hash_pop), 0);
        check("rst_ref_rd", 64'(bus.ref_rd), 0);
        check("rst_match", 64'(match_cnt), 0);
        do_reset();
        check("idle_busy", 64'(busy), 0);

        // three matching bundles
        rb = res_cnt; ab = addr_cnt; pb = pop_cnt;
        pulse_start();
        check("t1_busy", 64'(busy), 1);
        for (int i = 0; i < 3; i++) send_bundle(i);
        wait_res(rb + 3, 100);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            check("t1_idx", 64'(res_idx[(rb + i) % 64]), 64'(i));
            check("t1_ok", 64'(res_ok[(rb + i) % 64]), 1);
        end
        check("t1_latency", 64'(res_cyc[rb % 64] - pop_cyc[pb % 64]), 6);
        check("t1_spacing", 64'(res_cyc[(rb + 1) % 64] - res_cyc[rb % 64]), 7);
        check("t1_match", 64'(match_cnt), 3);
        check("t1_mismatch", 64'(mismatch_cnt), 0);
        check("t1_done", 64'(done), 1);
        check("t1_busy_end", 64'(busy), 0);
        check("t1_addr_cnt", 64'(addr_cnt - ab), 12);
        for (int k = 0; k < 12; k++) check("t1_addr", 64'(addr_log[(ab + k) % 64]), 64'(k));

        // corrupted word, no halt
        load_mem(1'b1);
        halt_on_err = 1'b0;
        rb = res_cnt;
        pulse_start();
        check("t2_done_cleared", 64'(done), 0);
        for (int i = 0; i < 3; i++) send_bundle(i);
        wait_res(rb + 3, 100);
        tick(2);
        check("t2_ok0", 64'(res_ok[rb % 64]), 1);
        check("t2_ok1", 64'(res_ok[(rb + 1) % 64]), 0);
        check("t2_ok2", 64'(res_ok[(rb + 2) % 64]), 1);
        check("t2_match", 64'(match_cnt), 2);
        check("t2_mismatch", 64'(mismatch_cnt), 1);
        check("t2_done", 64'(done), 1);

        // corrupted word, halt on error
        halt_on_err = 1'b1;
        rb = res_cnt;
        pulse_start();
        for (int i = 0; i < 3; i++) send_bundle(i);
        wait_res(rb + 2, 100);
        tick(2);
        check("t3_ok1", 64'(res_ok[(rb + 1) % 64]), 0);
        check("t3_halted", 64'(halted), 1);
        check("t3_busy", 64'(busy), 0);
        check("t3_done", 64'(done), 0);
        check("t3_match", 64'(match_cnt), 1);
        check("t3_mismatch", 64'(mismatch_cnt), 1);
        pb = pop_cnt;
        bundle_done = 1'b1;
        tick(1);
        bundle_done = 1'b0;
        tick(20);
        check("t3_no_pop", 64'(pop_cnt - pb), 0);
        check("t3_no_result", 64'(res_cnt - rb), 2);
        check("t3_still_halted", 64'(halted), 1);
        hq_wr = hq_rd;
        pulse_start();
        check("t3_restart_halted", 64'(halted), 0);
        check("t3_restart_mismatch", 64'(mismatch_cnt), 0);
        check("t3_restart_busy", 64'(busy), 1);
        rb = res_cnt;
        send_bundle(0);
        wait_res(rb + 1, 40);
        check("t3_rearm_ok", 64'(res_ok[rb % 64]), 1);
        check("t3_rearm_idx", 64'(res_idx[rb % 64]), 0);
        halt_on_err = 1'b0;

        // hash_valid with no pending bundle
        load_mem(1'b0);
        do_reset();
        pb = pop_cnt;
        rb = res_cnt;
        pulse_start();
        push_hash(0);
        tick(3);
        check("t4_err_proto", 64'(err_proto), 1);
        check("t4_no_pop", 64'(pop_cnt - pb), 0);
        bundle_done = 1'b1;
        tick(1);
        bundle_done = 1'b0;
        popped = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!popped) begin
                tick(1);
                if (pop_cnt != pb) popped = 1'b1;
            end
        end
        check("t4_pop_in_2", 64'(popped), 1);
        wait_res(rb + 1, 40);
        check("t4_ok", 64'(res_ok[rb % 64]), 1);

        // back-to-back bundle_done then held hash_valid
        do_reset();
        rb = res_cnt;
        pulse_start();
        bundle_done = 1'b1;
        tick(2);
        bundle_done = 1'b0;
        push_hash(0);
        push_hash(1);
        wait_res(rb + 2, 60);
        tick(2);
        check("t5_spacing", 64'(res_cyc[(rb + 1) % 64] - res_cyc[rb % 64]), 7);
        check("t5_ok0", 64'(res_ok[rb % 64]), 1);
        check("t5_ok1", 64'(res_ok[(rb + 1) % 64]), 1);
        check("t5_pending", 64'(dut.pending), 0);
        check("t5_err_proto", 64'(err_proto), 0);

        // overflow: fourth bundle with N_HASH = 3
        do_reset();
        rb = res_cnt;
        pulse_start();
        bundle_done = 1'b1;
        tick(3);
        check("t6_no_ovf_yet", 64'(err_ovf), 0);
        tick(1);
        bundle_done = 1'b0;
        check("t6_err_ovf", 64'(err_ovf), 1);
        for (int i = 0; i < 3; i++) push_hash(i);
        wait_res(rb + 3, 100);
        tick(2);
        check("t6_done", 64'(done), 1);
        check("t6_match", 64'(match_cnt), 3);

        // reset in the middle of a compare
        do_reset();
        pulse_start();
        pb = pop_cnt;
        rb = res_cnt;
        send_bundle(0);
        begin
            int k = 0;
            while (pop_cnt == pb && k < 20) begin
                tick(1);
                k++;
            end
        end
        check("t7_popped", 64'(pop_cnt - pb), 1);
        tick(2);
        rstn = 1'b0;
        #1;
        check("t7_busy", 64'(busy), 0);
        check("t7_ref_rd", 64'(bus.ref_rd), 0);
        check("t7_ref_addr", 64'(bus.ref_addr), 0);
        check("t7_match", 64'(match_cnt), 0);
        check("t7_err_ovf", 64'(err_ovf), 0);
        tick(10);
        check("t7_no_result", 64'(res_cnt - rb), 0);
        check("t7_chk_valid", 64'(chk_valid), 0);
        rstn = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
